// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for the external data bus: one transaction at a
// time, registered handshakes, and a timeout abort when the slave never acks.
module bus_arbiter #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_wr_rd,
  output logic              m0_gnt,
  output logic              m0_done,
  output logic              m0_err,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_wr_rd,
  output logic              m1_gnt,
  output logic              m1_done,
  output logic              m1_err,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] addr,
  output logic              cs,
  output logic              wr_rd,
  output logic [DATA_W-1:0] data_bus_write,
  input  logic [DATA_W-1:0] data_bus_read,
  input  logic              ack
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              owner, owner_n;
  logic              last, last_n;
  logic              sel;
  logic [ADDR_W-1:0] addr_n;
  logic              wr_rd_n;
  logic [DATA_W-1:0] wdata_n;
  logic              m0_gnt_n, m1_gnt_n, m0_done_n, m1_done_n, m0_err_n, m1_err_n;
  logic [DATA_W-1:0] m0_rdata_n, m1_rdata_n;

  // cs tracks BUSY directly; state is registered, so there is no input-to-output path
  assign cs = (state == BUSY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      owner          <= 1'b0;
      last           <= 1'b1;
      addr           <= '0;
      wr_rd          <= 1'b0;
      data_bus_write <= '0;
      m0_gnt         <= 1'b0;
      m1_gnt         <= 1'b0;
      m0_done        <= 1'b0;
      m1_done        <= 1'b0;
      m0_err         <= 1'b0;
      m1_err         <= 1'b0;
      m0_rdata       <= '0;
      m1_rdata       <= '0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      owner          <= owner_n;
      last           <= last_n;
      addr           <= addr_n;
      wr_rd          <= wr_rd_n;
      data_bus_write <= wdata_n;
      m0_gnt         <= m0_gnt_n;
      m1_gnt         <= m1_gnt_n;
      m0_done        <= m0_done_n;
      m1_done        <= m1_done_n;
      m0_err         <= m0_err_n;
      m1_err         <= m1_err_n;
      m0_rdata       <= m0_rdata_n;
      m1_rdata       <= m1_rdata_n;
    end
  end

  // Next-state logic also computes the next value of every registered output.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    owner_n    = owner;
    last_n     = last;
    sel        = 1'b0;
    addr_n     = addr;
    wr_rd_n    = wr_rd;
    wdata_n    = data_bus_write;
    m0_gnt_n   = 1'b0;
    m1_gnt_n   = 1'b0;
    m0_done_n  = 1'b0;
    m1_done_n  = 1'b0;
    m0_err_n   = 1'b0;
    m1_err_n   = 1'b0;
    m0_rdata_n = m0_rdata;
    m1_rdata_n = m1_rdata;

    unique case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          sel      = (m0_req && m1_req) ? ~last : m1_req;
          state_n  = BUSY;
          owner_n  = sel;
          last_n   = sel;
          cnt_n    = '0;
          addr_n   = sel ? m1_addr  : m0_addr;
          wr_rd_n  = sel ? m1_wr_rd : m0_wr_rd;
          wdata_n  = sel ? m1_wdata : m0_wdata;
          m0_gnt_n = ~sel;
          m1_gnt_n = sel;
        end
      end
      BUSY: begin
        if (ack) begin
          state_n = IDLE;
          if (owner) begin
            m1_done_n  = 1'b1;
            m1_rdata_n = data_bus_read;
          end else begin
            m0_done_n  = 1'b1;
            m0_rdata_n = data_bus_read;
          end
        end else if (cnt == CNT_LAST) begin
          state_n = IDLE;
          if (owner) begin
            m1_done_n  = 1'b1;
            m1_err_n   = 1'b1;
            m1_rdata_n = '0;
          end else begin
            m0_done_n  = 1'b1;
            m0_err_n   = 1'b1;
            m0_rdata_n = '0;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with TIMEOUT = 4: single read, round-robin
// ties, write field latching, timeout abort, ack-on-timeout and mid-transaction reset.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_wr_rd, m1_req, m1_wr_rd;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] addr, data_bus_write, data_bus_read;
  logic        cs, wr_rd, ack;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  bus_arbiter #(.TIMEOUT(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wr_rd(m0_wr_rd),
    .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wr_rd(m1_wr_rd),
    .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .addr(addr), .cs(cs), .wr_rd(wr_rd), .data_bus_write(data_bus_write),
    .data_bus_read(data_bus_read), .ack(ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    m0_req = 1'b0; m0_wr_rd = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_wr_rd = 1'b0; m1_addr = '0; m1_wdata = '0;
    data_bus_read = '0; ack = 1'b0;
    tick();
    tick();
    check("rst_cs", 32'(cs), 32'h0);
    check("rst_gnt", 32'({m0_gnt, m1_gnt}), 32'h0);
    check("rst_done_err", 32'({m0_done, m1_done, m0_err, m1_err}), 32'h0);
    check("rst_rdata", m0_rdata | m1_rdata, 32'h0);
    check("rst_bus", addr | data_bus_write | 32'(wr_rd), 32'h0);
    rst = 1'b0;
    tick();

    // Single master 0 read, ack in the 3rd BUSY cycle
    m0_req = 1'b1; m0_addr = 32'h0000_0200; m0_wr_rd = 1'b0;
    tick();
    check("t1_gnt0", 32'(m0_gnt), 32'h1);
    check("t1_gnt1", 32'(m1_gnt), 32'h0);
    check("t1_cs", 32'(cs), 32'h1);
    check("t1_addr", addr, 32'h0000_0200);
    check("t1_wr_rd", 32'(wr_rd), 32'h0);
    m0_req = 1'b0;
    tick();
    check("t1_cs2", 32'(cs), 32'h1);
    check("t1_gnt_pulse", 32'(m0_gnt), 32'h0);
    tick();
    check("t1_cs3", 32'(cs), 32'h1);
    check("t1_nodone", 32'(m0_done), 32'h0);
    ack = 1'b1; data_bus_read = 32'hDEAD_BEEF;
    tick();
    check("t1_cs_low", 32'(cs), 32'h0);
    check("t1_done", 32'(m0_done), 32'h1);
    check("t1_err", 32'(m0_err), 32'h0);
    check("t1_rdata", m0_rdata, 32'hDEAD_BEEF);
    check("t1_m1_quiet", 32'({m1_gnt, m1_done, m1_err}) | m1_rdata, 32'h0);
    ack = 1'b0; data_bus_read = '0;
    tick();
    check("t1_done_pulse", 32'(m0_done), 32'h0);
    check("t1_rdata_hold", m0_rdata, 32'hDEAD_BEEF);

    // Both request continuously with ack high; m0 was granted last, so m1 goes first
    m0_req = 1'b1; m1_req = 1'b1; m0_addr = 32'hA0; m1_addr = 32'hB0; ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic exp1;
      exp1 = (i % 2 == 0);
      tick();
      check("rr_gnt1", 32'(m1_gnt), 32'(exp1));
      check("rr_gnt0", 32'(m0_gnt), 32'(!exp1));
      check("rr_addr", addr, exp1 ? 32'hB0 : 32'hA0);
      data_bus_read = 32'h1000 + 32'(i);
      tick();
      check("rr_cs_low", 32'(cs), 32'h0);
      check("rr_done1", 32'(m1_done), 32'(exp1));
      check("rr_done0", 32'(m0_done), 32'(!exp1));
      check("rr_rdata", exp1 ? m1_rdata : m0_rdata, 32'h1000 + 32'(i));
    end
    m0_req = 1'b0; m1_req = 1'b0; ack = 1'b0;
    tick();
    check("rr_idle", 32'(cs), 32'h0);

    // Master 1 write; master scribbles its fields right after gnt
    m1_req = 1'b1; m1_addr = 32'h10; m1_wdata = 32'h1234; m1_wr_rd = 1'b1;
    tick();
    check("t3_gnt1", 32'(m1_gnt), 32'h1);
    m1_req = 1'b0; m1_addr = 32'hFFFF; m1_wdata = 32'h5555; m1_wr_rd = 1'b0;
    tick();
    check("t3_addr", addr, 32'h10);
    check("t3_wdata", data_bus_write, 32'h1234);
    check("t3_wr_rd", 32'(wr_rd), 32'h1);
    check("t3_cs", 32'(cs), 32'h1);
    ack = 1'b1; data_bus_read = 32'h77;
    tick();
    check("t3_done1", 32'(m1_done), 32'h1);
    check("t3_err1", 32'(m1_err), 32'h0);
    check("t3_rdata1", m1_rdata, 32'h77);
    check("t3_m0_rdata_kept", m0_rdata, 32'h1003);
    ack = 1'b0; data_bus_read = '0;

    // Timeout: no ack, cs high exactly 4 cycles
    m0_req = 1'b1; m0_addr = 32'h300;
    tick();
    check("t4_gnt0", 32'(m0_gnt), 32'h1);
    m0_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_cs_high", 32'(cs), 32'h1);
      check("t4_nodone", 32'(m0_done), 32'h0);
    end
    tick();
    check("t4_cs_low", 32'(cs), 32'h0);
    check("t4_done", 32'(m0_done), 32'h1);
    check("t4_err", 32'(m0_err), 32'h1);
    check("t4_rdata0", m0_rdata, 32'h0);
    tick();
    check("t4_err_pulse", 32'({m0_done, m0_err}), 32'h0);

    // ack on the same edge as the timeout: ack wins
    m0_req = 1'b1; m0_addr = 32'h400;
    tick();
    check("t5_gnt0", 32'(m0_gnt), 32'h1);
    m0_req = 1'b0;
    tick();
    tick();
    tick();
    check("t5_cs_high", 32'(cs), 32'h1);
    ack = 1'b1; data_bus_read = 32'hCAFE_F00D;
    tick();
    check("t5_done", 32'(m0_done), 32'h1);
    check("t5_err", 32'(m0_err), 32'h0);
    check("t5_rdata", m0_rdata, 32'hCAFE_F00D);
    ack = 1'b0; data_bus_read = '0;

    // Reset in the 2nd BUSY cycle (m0 granted last, so the tie goes to m1)
    m0_req = 1'b1; m1_req = 1'b1; m1_addr = 32'h500;
    tick();
    check("t6_gnt1", 32'(m1_gnt), 32'h1);
    m0_req = 1'b0; m1_req = 1'b0;
    tick();
    check("t6_cs_busy", 32'(cs), 32'h1);
    rst = 1'b1;
    tick();
    check("t6_cs_low", 32'(cs), 32'h0);
    check("t6_nodone", 32'({m0_done, m1_done}), 32'h0);
    check("t6_addr_rst", addr, 32'h0);
    check("t6_rdata_rst", m1_rdata | m0_rdata, 32'h0);
    rst = 1'b0; m0_req = 1'b1; m1_req = 1'b1;
    tick();
    check("t6_tie_gnt0", 32'(m0_gnt), 32'h1);
    check("t6_tie_gnt1", 32'(m1_gnt), 32'h0);
    m0_req = 1'b0; m1_req = 1'b0; ack = 1'b1; data_bus_read = 32'h99;
    tick();
    check("t6_done0", 32'(m0_done), 32'h1);
    check("t6_rdata0", m0_rdata, 32'h99);
    ack = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
